// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared constants for the multiply/divide sequencer: FSM state encodings,
// operation select encodings and the default watchdog limit.
package muldiv_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_DZERO  = 3'd4;
    localparam logic [2:0] ST_TOUT   = 3'd5;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int MAX_CYCLES_DEF = 40;

endpackage

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Sequences the iterative multiplier/divider for the control unit: accepts a
// start request, screens divide-by-zero, launches the selected unit, waits for
// its completion under a watchdog, then drives the HI/LO write and done.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   start       request pulse, sampled only in IDLE
//   op          0 = mult, 1 = div, sampled with start
//   operand_b   divisor, sampled with start
//   unit_done   completion strobe from the launched unit (honoured in WAIT only)
//   mult_start  one-cycle multiplier launch
//   div_start   one-cycle divider launch
//   hi_src      HI mux select (0 mult, 1 div)
//   lo_src      LO mux select (0 mult, 1 div)
//   hilo_write  HI/LO register write-enable
//   busy        high in every state except IDLE
//   done        one-cycle completion pulse (success, div-zero or timeout)
//   div_zero    one-cycle divide-by-zero pulse
//   timeout     one-cycle watchdog abort pulse
//
// state  | meaning
// IDLE   | waiting for start
// LAUNCH | pulse start to the selected unit, clear watchdog
// WAIT   | unit running, watchdog counting
// WRITE  | capture result into HI/LO, signal done
// DZERO  | divisor was zero, signal exception and done
// TOUT   | unit never finished, signal abort and done
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MAX_CYCLES = MAX_CYCLES_DEF,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] operand_b,
    input  logic        unit_done,
    output logic        mult_start,
    output logic        div_start,
    output logic        hi_src,
    output logic        lo_src,
    output logic        hilo_write,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        timeout
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_CYCLES - 1);

    logic [2:0]       state;
    logic             op_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            op_q  <= OP_MULT;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= op;
                        if (op == OP_DIV && operand_b == 32'd0)
                            state <= ST_DZERO;
                        else
                            state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // completion takes priority over the watchdog limit
                    if (unit_done)
                        state <= ST_WRITE;
                    else if (cnt == CNT_LIMIT)
                        state <= ST_TOUT;
                end
                ST_WRITE, ST_DZERO, ST_TOUT: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic src_active;
    assign src_active = (state == ST_LAUNCH) || (state == ST_WAIT) || (state == ST_WRITE);

    assign mult_start = (state == ST_LAUNCH) && (op_q == OP_MULT);
    assign div_start  = (state == ST_LAUNCH) && (op_q == OP_DIV);
    assign hi_src     = src_active && op_q;
    assign lo_src     = src_active && op_q;
    assign hilo_write = (state == ST_WRITE);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_WRITE) || (state == ST_DZERO) || (state == ST_TOUT);
    assign div_zero   = (state == ST_DZERO);
    assign timeout    = (state == ST_TOUT);

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    localparam int MAXC = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] operand_b;
    logic        unit_done;
    logic        mult_start, div_start, hi_src, lo_src, hilo_write;
    logic        busy, done, div_zero, timeout;

    int n_vec = 0;
    int n_err = 0;

    muldiv_sequencer #(.MAX_CYCLES(MAXC), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .operand_b  (operand_b),
        .unit_done  (unit_done),
        .mult_start (mult_start),
        .div_start  (div_start),
        .hi_src     (hi_src),
        .lo_src     (lo_src),
        .hilo_write (hilo_write),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // {mult_start, div_start, hi_src, lo_src, hilo_write, busy, done, div_zero, timeout}
    function automatic logic [8:0] obs();
        return {mult_start, div_start, hi_src, lo_src, hilo_write, busy, done, div_zero, timeout};
    endfunction

    task automatic chk_vec(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller is positioned in cycle 0 (idle). Start is issued in cycle 0;
    // unit_done is driven in cycle done_at (-1 = never); extra start pulses in
    // cycles ign1/ign2 carry a div-by-zero request that must be ignored.
    task automatic run_case(input string name, input logic op_v, input logic [31:0] b_v,
                            input int done_at, input int ign1, input int ign2, input int n_cyc);
        bit          dz;
        bit          tout;
        int          end_c;
        logic [8:0]  e;
        bit          act;
        dz    = op_v && (b_v == 32'd0);
        tout  = !dz && (done_at < 0);
        end_c = dz ? 1 : (tout ? MAXC + 2 : done_at + 1);
        start     = 1'b1;
        op        = op_v;
        operand_b = b_v;
        unit_done = 1'b0;
        for (int c = 1; c <= n_cyc; c++) begin
            step();
            start     = (c == ign1) || (c == ign2);
            op        = 1'b1;
            operand_b = 32'd0;
            unit_done = (c == done_at);
            act  = (c <= end_c);
            e[8] = !dz && (c == 1) && !op_v;
            e[7] = !dz && (c == 1) && op_v;
            e[6] = act && !dz && op_v && !(tout && c == end_c);
            e[5] = e[6];
            e[4] = (c == end_c) && !dz && !tout;
            e[3] = act;
            e[2] = (c == end_c);
            e[1] = dz && (c == end_c);
            e[0] = tout && (c == end_c);
            chk_vec($sformatf("%s c%0d", name, c), obs(), e);
        end
        start     = 1'b0;
        unit_done = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        op        = 1'b0;
        operand_b = 32'd0;
        unit_done = 1'b0;
        #1;
        chk_vec("reset_t0", obs(), 9'b0);
        step();
        step();
        chk_vec("reset_held", obs(), 9'b0);
        reset = 1'b0;
        step();
        chk_vec("idle_after_reset", obs(), 9'b0);

        run_case("mult",      1'b0, 32'd7,  34,  0, 0, 36);
        run_case("div",       1'b1, 32'd3,  10,  0, 0, 12);
        run_case("divzero",   1'b1, 32'd0,  -1,  0, 0, 3);
        run_case("tout",      1'b0, 32'd9,  -1,  0, 0, 43);
        run_case("done_lim",  1'b1, 32'd5,  41,  0, 0, 43);
        run_case("done_min",  1'b0, 32'd1,   2,  0, 0, 4);
        // ignored mid-run starts, then a start in the cycle right after done
        run_case("ignored",   1'b0, 32'd2,  12,  3, 6, 14);
        run_case("b2b",       1'b1, 32'd5,   4,  0, 0, 6);

        // reset in the middle of a divide
        start     = 1'b1;
        op        = 1'b1;
        operand_b = 32'd3;
        for (int c = 1; c <= 4; c++) begin
            step();
            start     = 1'b0;
            operand_b = 32'd0;
        end
        chk_vec("rst_pre_c4", obs(), 9'b0_0110_1000);
        step();
        reset = 1'b1;
        #1;
        chk_vec("rst_async_c5", obs(), 9'b0);
        #2;
        reset = 1'b0;
        for (int c = 6; c <= 12; c++) begin
            step();
            unit_done = (c == 8);
            chk_vec($sformatf("rst_after c%0d", c), obs(), 9'b0);
        end
        unit_done = 1'b0;

        run_case("post_rst",  1'b0, 32'd4,   3,  0, 0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the iterative multiplier and divider on behalf of the main control unit.
- Accepts one start request, pre-checks divide-by-zero, launches the selected unit and waits for its completion.
- Drives the HI/LO source selects and HILO write-enable, then signals done.
- Watchdog aborts an operation whose unit never completes; the control unit stalls on busy.

Parameters:
- MAX_CYCLES, 40, maximum number of WAIT cycles before timeout abort (must be at least 2).
- CNT_W, 6, watchdog counter width; must hold MAX_CYCLES-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse from control unit; sampled only in IDLE.
- op  input  1  0 = mult, 1 = div; sampled with start.
- operand_b  input  32  divisor (B register value); sampled with start.
- unit_done  input  1  completion strobe from the launched mult/div unit.
- mult_start  output  1  one-cycle launch pulse to multiplier.
- div_start  output  1  one-cycle launch pulse to divider.
- hi_src  output  1  HI mux select (0 mult, 1 div).
- lo_src  output  1  LO mux select (0 mult, 1 div).
- hilo_write  output  1  HI/LO register write-enable.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse (success, div-zero or timeout).
- div_zero  output  1  one-cycle divide-by-zero exception pulse.
- timeout  output  1  one-cycle watchdog abort pulse.

Behaviour:
- Moore FSM; all outputs decoded from registered state, latched op and counter. No combinational path from inputs to outputs.
- Reset (async): state IDLE, op_q=0, cnt=0; every output 0. Reset mid-operation aborts immediately; no hilo_write is issued.
- States: IDLE, LAUNCH, WAIT, WRITE, DZERO, TOUT.
- IDLE:
  - On start=1, latch op into op_q.
  - If op=1 and operand_b==0, go to DZERO; otherwise go to LAUNCH.
  - start=0: stay in IDLE.
- LAUNCH (1 cycle): mult_start=~op_q, div_start=op_q; cnt cleared to 0; go to WAIT.
- WAIT: cnt increments each cycle.
  - unit_done=1: go to WRITE.
  - Else cnt==MAX_CYCLES-1: go to TOUT.
  - unit_done and limit in the same cycle: WRITE wins.
- WRITE (1 cycle): hilo_write=1, done=1; go to IDLE. HI/LO capture at the end of this cycle.
- DZERO (1 cycle): div_zero=1, done=1, no launch, no hilo_write; go to IDLE.
- TOUT (1 cycle): timeout=1, done=1, no hilo_write; go to IDLE.
- hi_src = lo_src = op_q in LAUNCH, WAIT and WRITE; 0 in all other states.
- start while busy is ignored and not queued. unit_done outside WAIT is ignored.
- Latency:
  - start accepted at cycle 0; launch pulse at cycle 1; WAIT from cycle 2.
  - unit_done at cycle k (k≥2) gives WRITE/done at cycle k+1.
  - Div-by-zero: done at cycle 1.
  - Timeout: done at cycle MAX_CYCLES+2.
- Back-to-back: a new start may be accepted in the cycle after done (state is IDLE).

Decomposition:
- Shared package muldiv_pkg:
  - state enumeration;
  - OP_MULT=1'b0, OP_DIV=1'b1;
  - default MAX_CYCLES.
- No sub-module needed; the watchdog is an inline counter.

Test Plan:
- Mult:
  - Stimulus: start=1, op=0, operand_b=7 at cycle 0; unit_done at cycle 34.
  - Response: mult_start=1 at cycle 1 only; busy cycles 1-35; hilo_write=done=1 at cycle 35; hi_src=lo_src=0 throughout.
- Div:
  - Stimulus: start=1, op=1, operand_b=3; unit_done at cycle 10.
  - Response: div_start=1 at cycle 1; hi_src=lo_src=1 cycles 1-11; hilo_write=done=1 at cycle 11.
- Div-by-zero:
  - Stimulus: start=1, op=1, operand_b=0.
  - Response: div_zero=done=1 at cycle 1; div_start, hilo_write never asserted; busy only at cycle 1.
- Timeout:
  - Stimulus: MAX_CYCLES=40, mult start, unit_done never asserted.
  - Response: timeout=done=1 at cycle 42, no hilo_write; state IDLE at cycle 43.
- Reset during WAIT:
  - Stimulus: assert reset at cycle 5 of a div.
  - Response: all outputs 0 immediately (asynchronous); unit_done at cycle 8 produces no hilo_write.
- Ignored requests:
  - Stimulus: start pulses at cycles 3 and 6 during a running mult, then a start in the cycle after done.
  - Response: mid-run starts have no effect; the post-done start launches normally one cycle later.
